// File: rtl/morse_decoder_pkg.sv
// Interval constants shared by the Morse decoder timer instances,
// plus the counter-width helper used by tick_timer.
package morse_decoder_pkg;

    // Cycle counts for each decoder interval.
    // Two orderings must hold: dash < illegal symbol, and inter-symbol idle < word idle.
    localparam int unsigned DASH_TICK_COUNT_C           = 3;
    localparam int unsigned INTER_IDLE_TICK_COUNT_C     = 5;
    localparam int unsigned ILLEGAL_SYMBOL_TICK_COUNT_C = 7;
    localparam int unsigned WORD_IDLE_TICK_COUNT_C      = 10;

    // Width of a counter that must be able to hold the value n.
    function automatic int unsigned tick_cnt_width(input int unsigned n);
        return $clog2(n + 1);
    endfunction

endpackage

// File: rtl/tick_timer.sv
// One-shot interval timer. After reset is released it counts rising edges of
// clk. expired_o is a registered, sticky flag. It rises on the TICK_COUNT-th
// edge after reset release and can only be cleared by reset.
module tick_timer
    import morse_decoder_pkg::*;
#(
    parameter int unsigned TICK_COUNT = 16,
    // Derived from TICK_COUNT. Do not override this parameter.
    parameter int unsigned CNT_W      = tick_cnt_width(TICK_COUNT)
) (
    input  logic clk,
    input  logic resetn,
    output logic expired_o
);

    localparam logic [CNT_W-1:0] TERM_C    = CNT_W'(TICK_COUNT);
    localparam logic [CNT_W-1:0] TERM_M1_C = CNT_W'(TICK_COUNT - 1);

    logic [CNT_W-1:0] cnt;

    // Saturating up-counter. The expiry flag is set on the same edge that the
    // counter reaches its terminal value, so the flag needs no extra cycle.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            cnt       <= '0;
            expired_o <= 1'b0;
        end else if (cnt != TERM_C) begin
            cnt <= cnt + CNT_W'(1);
            if (cnt == TERM_M1_C) begin
                expired_o <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_tick_timer.sv
// Directed bench for tick_timer. It uses several instances with different
// TICK_COUNT values on a shared clk and resetn.
module tb_tick_timer;
    import morse_decoder_pkg::*;

    logic clk;
    logic resetn;
    logic exp8, exp1, exp_dash, exp_inter, exp_ill, exp_word;

    int vectors;
    int miscompares;

    tick_timer #(.TICK_COUNT(8)) dut8 (.clk(clk), .resetn(resetn), .expired_o(exp8));
    tick_timer #(.TICK_COUNT(1)) dut1 (.clk(clk), .resetn(resetn), .expired_o(exp1));
    tick_timer #(.TICK_COUNT(DASH_TICK_COUNT_C)) dut_dash
        (.clk(clk), .resetn(resetn), .expired_o(exp_dash));
    tick_timer #(.TICK_COUNT(INTER_IDLE_TICK_COUNT_C)) dut_inter
        (.clk(clk), .resetn(resetn), .expired_o(exp_inter));
    tick_timer #(.TICK_COUNT(ILLEGAL_SYMBOL_TICK_COUNT_C)) dut_ill
        (.clk(clk), .resetn(resetn), .expired_o(exp_ill));
    tick_timer #(.TICK_COUNT(WORD_IDLE_TICK_COUNT_C)) dut_word
        (.clk(clk), .resetn(resetn), .expired_o(exp_word));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Move to the next rising edge, then sample 1 time unit after it.
    task automatic tick(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic check(input string tag, input logic obs, input logic expv);
        vectors++;
        assert (obs === expv) else begin
            miscompares++;
            $error("FAIL %s observed=%b expected=%b", tag, obs, expv);
        end
    endtask

    // Assert reset between clock edges and check that every output clears
    // without waiting for an edge.
    task automatic async_reset(input string tag);
        #2 resetn = 1'b0;
        #1;
        check({tag, "_8"},    exp8,      1'b0);
        check({tag, "_1"},    exp1,      1'b0);
        check({tag, "_word"}, exp_word,  1'b0);
    endtask

    initial begin
        vectors     = 0;
        miscompares = 0;
        resetn      = 1'b0;

        // Outputs stay low while reset is held, even with clock edges present.
        tick(3);
        check("rst_8",     exp8,      1'b0);
        check("rst_1",     exp1,      1'b0);
        check("rst_dash",  exp_dash,  1'b0);
        check("rst_inter", exp_inter, 1'b0);
        check("rst_ill",   exp_ill,   1'b0);
        check("rst_word",  exp_word,  1'b0);

        // Test 1: release reset, run 4 edges, then reset again. The 8-tick timer never expires.
        resetn = 1'b1;
        for (int e = 1; e <= 4; e++) begin
            tick(1);
            check($sformatf("t1_e%0d", e), exp8, 1'b0);
        end
        async_reset("t1_rst");
        tick(2);
        check("t1_held", exp8, 1'b0);

        // Tests 2, 3 and 5: a 15-edge run checks every instance at every edge.
        resetn = 1'b1;
        for (int e = 1; e <= 15; e++) begin
            tick(1);
            check($sformatf("e%0d_8", e),     exp8,      1'(e >= 8));
            check($sformatf("e%0d_1", e),     exp1,      1'b1);
            check($sformatf("e%0d_dash", e),  exp_dash,  1'(e >= 3));
            check($sformatf("e%0d_inter", e), exp_inter, 1'(e >= 5));
            check($sformatf("e%0d_ill", e),   exp_ill,   1'(e >= 7));
            check($sformatf("e%0d_word", e),  exp_word,  1'(e >= 10));
        end

        // Long run with no reset: the outputs stay high and the counters never wrap.
        for (int e = 0; e < 40; e++) begin
            tick(7);
            check($sformatf("sat%0d_1", e), exp1,     1'b1);
            check($sformatf("sat%0d_8", e), exp8,     1'b1);
            check($sformatf("sat%0d_w", e), exp_word, 1'b1);
        end

        // Test 4: an asynchronous clear after expiry, then the timer expires again at edge 8.
        async_reset("t4_rst");
        tick(1);
        check("t4_held", exp8, 1'b0);
        resetn = 1'b1;
        for (int e = 1; e <= 10; e++) begin
            tick(1);
            check($sformatf("t4_e%0d", e), exp8, 1'(e >= 8));
        end

        // Test 6: reset pulse at edge 6. There is no expiry at the original edge 8,
        // and expiry comes 8 edges after the new release.
        async_reset("t6_pre");
        resetn = 1'b1;
        tick(6);
        check("t6_e6", exp8, 1'b0);
        async_reset("t6_mid");
        tick(1);
        resetn = 1'b1;
        for (int e = 1; e <= 9; e++) begin
            tick(1);
            check($sformatf("t6_e%0d", e),    exp8,     1'(e >= 8));
            check($sformatf("t6_e%0d_w", e),  exp_word, 1'b0);
            check($sformatf("t6_e%0d_1", e),  exp1,     1'b1);
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/tick_timer.md
Name: tick_timer

Overview:
- Free-running one-shot interval timer for the Morse decoder.
- After reset is released it counts clock cycles and raises a sticky expired flag once TICK_COUNT cycles have elapsed.
- Restart is only through reset.
- The decoder instantiates one copy per interval: dash threshold, illegal-symbol timeout, inter-symbol idle, and word idle. Each copy takes its TICK_COUNT from the shared package.

Parameters:
- TICK_COUNT, default 16: number of rising clk edges after reset release before expired_o asserts. Legal range is 1 to 2^31-1.
- CNT_W, default $clog2(TICK_COUNT+1): counter width. It is derived and must not be overridden.

Ports:
- clk  input  1  system clock; all state updates on the rising edge.
- resetn  input  1  asynchronous, active-low reset. It restarts the timer.
- expired_o  output  1  high once TICK_COUNT cycles have elapsed since reset release; stays high (sticky) until the next reset.

Behaviour:
- Interface: one clock, clk. resetn is an asynchronous, active-low reset.
- Reset: while resetn=0, the counter is 0 and expired_o=0, taking effect immediately without waiting for a clock edge.
- Counting: on each rising clk edge with resetn=1 and the counter below TICK_COUNT, the counter increments by 1.
- Expiry: expired_o is a registered output. It becomes 1 on the same edge that the counter reaches TICK_COUNT, i.e. the TICK_COUNT-th rising edge after resetn deasserts.
- Latency: for TICK_COUNT=N, expired_o is 0 for edges 1..N-1 and 1 from edge N onward.
- Saturation: once the counter equals TICK_COUNT it holds and never wraps, so expired_o stays 1 indefinitely. A long run without reset must not re-arm or glitch the output.
- Reset mid-count: asserting resetn at any time, before or after expiry, clears the counter and expired_o asynchronously. Counting restarts from 0 on the first edge after deassertion.
- Reset-release edge: the first edge at which resetn is sampled high counts as edge 1. Reset deassertion is assumed synchronised upstream.
- TICK_COUNT=1: expired_o rises on the first edge after reset release.
- No combinational path from any input to expired_o other than the asynchronous reset clear.
- Multiple instances with different TICK_COUNT share clk and resetn and must be independent. For example, a word-idle instance must not expire early because a dash instance has already expired.

Decomposition:
- morse_decoder_pkg holds the interval constants: DASH_TICK_COUNT_C, ILLEGAL_SYMBOL_TICK_COUNT_C, INTER_IDLE_TICK_COUNT_C and WORD_IDLE_TICK_COUNT_C.
- Required ordering: DASH < ILLEGAL_SYMBOL, and INTER_IDLE < WORD_IDLE.
- The package also holds a helper for counter width if shared.
- No sub-module; a single flat module with a saturating counter and an expiry register.
- Bench stimulus helpers (reset pulse, wait N clocks) live in a shared include, not in the RTL.

Test Plan:
1. TICK_COUNT=8; release reset and wait 4 clocks, then re-assert reset -> expired_o stays 0 throughout and is 0 during reset.
2. TICK_COUNT=8; release reset and run 12 clocks -> expired_o is 0 through edge 7, 1 at edge 8, and still 1 at edge 12 (sticky, no wrap).
3. Four instances with TICK_COUNT 3, 5, 7, 10 on shared clk/resetn; run 15 clocks after reset -> each output rises exactly at edges 3, 5, 7 and 10 respectively and all stay high.
4. TICK_COUNT=8; let it expire, then assert resetn=0 between clock edges -> expired_o drops immediately (asynchronously). After release it rises again at edge 8.
5. TICK_COUNT=1; release reset -> expired_o=1 after the first edge.
6. TICK_COUNT=8; reset pulse at edge 6, then release -> no expiry at the original edge 8. Expiry occurs 8 edges after the new release.
